// File: rtl/uart_tx_io_pkg.sv
// Shared definitions for the UART transmitter: FSM states, CPU register offsets
// and STATUS register bit positions.
package uart_tx_io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_tx_state_t;

   // Writes decode DATA/CONTROL, reads decode DATA/STATUS on the same offset bit.
   localparam logic UART_DATA_OFFSET    = 1'b0;
   localparam logic UART_CONTROL_OFFSET = 1'b1;
   localparam logic UART_STATUS_OFFSET  = 1'b1;

   localparam int STAT_FULL_BIT     = 0;
   localparam int STAT_EMPTY_BIT    = 1;
   localparam int STAT_BUSY_BIT     = 2;
   localparam int STAT_OVERFLOW_BIT = 3;
   localparam int STAT_IRQ_EN_BIT   = 4;
   localparam int STAT_COUNT_LSB    = 8;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with occupancy count. Full and empty are judged on the state
// before the current edge, so a push into a full FIFO is refused even if a pop happens.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign pop_data  = r_mem[r_rd_ptr];
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers and count decide what is valid,
   // and leaving it out keeps the array mappable onto plain RAM/flops without reset.
   always_ff @(posedge clock) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a FIFO, the FSM
// serialises them LSB first and raises a sticky interrupt when the FIFO drains.
module uart_tx_io #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        write_enable,
   input  logic        write_offset,
   input  logic [15:0] write_data,
   input  logic        read_offset,
   output logic [15:0] read_data,
   input  logic        reset_irq,
   output logic        irq,
   output logic        txd
);

   import uart_tx_io_pkg::*;

   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   uart_tx_state_t r_state;
   logic [7:0]     r_shift;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [2:0]     r_bit_idx;
   logic           r_txd;
   logic           r_irq;
   logic           r_irq_en;
   logic           r_overflow;

   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic [CW-1:0]  w_count;
   logic [7:0]     w_head;
   logic           w_bit_done;
   logic [2:0]     w_idx_next;
   logic           w_irq_set;
   logic           w_overflow_set;
   logic [15:0]    w_read_data;
   logic           w_unused;

   assign w_push     = write_enable && (write_offset == UART_DATA_OFFSET);
   assign w_bit_done = (r_bit_cnt == BIT_LAST);
   assign w_idx_next = r_bit_idx + 3'd1;
   // The FIFO head is taken when idle, or at the end of STOP for gap-free frames.
   assign w_pop      = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done));
   assign w_irq_set      = (r_state == ST_STOP) && w_bit_done && w_empty && r_irq_en;
   assign w_overflow_set = w_push && w_full;
   assign w_unused       = ^write_data[15:8];

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push),
      .push_data (write_data[7:0]),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (w_count)
   );

   // NOTE: state and line are registered with non-blocking assignments so every
   // branch sees the pre-edge values; txd changes on the same edge as the state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_txd     <= 1'b1;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_txd     <= 1'b1;
               r_bit_cnt <= '0;
               r_bit_idx <= '0;
               if (!w_empty) begin
                  r_shift <= w_head;
                  r_state <= ST_START;
                  r_txd   <= 1'b0;
               end
            end
            ST_START: begin
               if (w_bit_done) begin
                  r_bit_cnt <= '0;
                  r_bit_idx <= '0;
                  r_txd     <= r_shift[0];
                  r_state   <= ST_DATA;
               end else begin
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (w_bit_done) begin
                  r_bit_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_txd   <= 1'b1;
                     r_state <= ST_STOP;
                  end else begin
                     r_bit_idx <= w_idx_next;
                     r_txd     <= r_shift[w_idx_next];
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (w_bit_done) begin
                  r_bit_cnt <= '0;
                  if (!w_empty) begin
                     r_shift <= w_head;
                     r_txd   <= 1'b0;
                     r_state <= ST_START;
                  end else begin
                     r_txd   <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // A same-cycle set outranks the CPU acknowledge so no event is lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_irq      <= 1'b0;
         r_overflow <= 1'b0;
         r_irq_en   <= 1'b0;
      end else begin
         if (w_irq_set)      r_irq <= 1'b1;
         else if (reset_irq) r_irq <= 1'b0;
         if (w_overflow_set) r_overflow <= 1'b1;
         else if (reset_irq) r_overflow <= 1'b0;
         if (write_enable && (write_offset == UART_CONTROL_OFFSET))
            r_irq_en <= write_data[0];
      end
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_read_data = '0;
      if (read_offset == UART_STATUS_OFFSET) begin
         w_read_data[STAT_FULL_BIT]         = w_full;
         w_read_data[STAT_EMPTY_BIT]        = w_empty;
         w_read_data[STAT_BUSY_BIT]         = (r_state != ST_IDLE);
         w_read_data[STAT_OVERFLOW_BIT]     = r_overflow;
         w_read_data[STAT_IRQ_EN_BIT]       = r_irq_en;
         w_read_data[STAT_COUNT_LSB +: CW]  = w_count;
      end
   end

   assign read_data = w_read_data;
   assign irq       = r_irq;
   assign txd       = r_txd;

endmodule

// File: tb/tb_uart_tx_io.sv
// Directed and randomised checks of uart_tx_io against a frame-level line model.
module tb_uart_tx_io;

   import uart_tx_io_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic        clock        = 1'b0;
   logic        reset        = 1'b0;
   logic        write_enable = 1'b0;
   logic        write_offset = 1'b0;
   logic [15:0] write_data   = '0;
   logic        read_offset  = 1'b0;
   logic [15:0] read_data;
   logic        reset_irq    = 1'b0;
   logic        irq;
   logic        txd;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] rx_q[$];
   int         rx_start_q[$];
   int         frame_err    = 0;
   int         irq_rises    = 0;
   int         irq_rise_cyc = -1;

   uart_tx_io #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .write_enable (write_enable),
      .write_offset (write_offset),
      .write_data   (write_data),
      .read_offset  (read_offset),
      .read_data    (read_data),
      .reset_irq    (reset_irq),
      .irq          (irq),
      .txd          (txd)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Line receiver: a frame starts at the first low sample, bits are read mid-cell.
   initial begin : line_monitor
      int         off;
      int         start_cyc;
      logic [7:0] b;
      bit         active;
      active = 1'b0;
      off = 0;
      start_cyc = 0;
      b = '0;
      forever begin
         @(negedge clock);
         if (reset !== 1'b1) begin
            active = 1'b0;
         end else if (!active) begin
            if (txd === 1'b0) begin
               active = 1'b1;
               off = 0;
               b = '0;
               start_cyc = cyc;
            end
         end else begin
            off++;
            if (off == CPB / 2 && txd !== 1'b0) frame_err++;
            if (off > CPB && off < 9 * CPB && (off % CPB) == CPB / 2)
               b[off / CPB - 1] = txd;
            if (off == 9 * CPB + CPB / 2) begin
               if (txd !== 1'b1) frame_err++;
               rx_q.push_back(b);
               rx_start_q.push_back(start_cyc);
               active = 1'b0;
            end
         end
      end
   end

   initial begin : irq_monitor
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (irq === 1'b1 && !prev) begin
            irq_rises++;
            irq_rise_cyc = cyc;
         end
         prev = (irq === 1'b1);
      end
   end

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   function automatic int start_of(input int i);
      if (i < rx_start_q.size()) return rx_start_q[i];
      return -1000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_reg(input logic off, input logic [15:0] d);
      @(negedge clock);
      write_enable = 1'b1;
      write_offset = off;
      write_data   = d;
      @(negedge clock);
      write_enable = 1'b0;
      write_data   = '0;
   endtask

   task automatic read_status(output logic [15:0] v);
      read_offset = UART_STATUS_OFFSET;
      #1;
      v = read_data;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_reset_irq();
      @(negedge clock);
      reset_irq = 1'b1;
      @(negedge clock);
      reset_irq = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clock);
         k++;
      end
      check(tag, rx_q.size(), n);
   endtask

   task automatic compare_rx(input string tag, input logic [7:0] exp[$]);
      check({tag, "_count"}, rx_q.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         check($sformatf("%s_byte%0d", tag, i),
               (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, exp[i]);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_start_q.delete();
   endtask

   initial begin : stimulus
      logic [15:0] v;
      logic [7:0]  b;
      logic [7:0]  exp[$];
      int          s;
      int          p;
      int          n;
      int          zeros;

      // Reset state
      idle(3);
      check("rst_txd", txd, 1);
      check("rst_irq", irq, 0);
      read_status(v);
      check("rst_status", v, 16'h0002);
      read_offset = UART_DATA_OFFSET;
      #1;
      check("data_read_zero", read_data, 0);
      @(negedge clock);
      reset = 1'b1;
      idle(2);

      // Single frame, exact waveform; upper data byte must be ignored
      clear_rx();
      write_reg(UART_DATA_OFFSET, 16'h3355);
      check("p1_txd_before", txd, 1);
      @(negedge clock);
      for (int k = 0; k < FRAME; k++) begin
         check($sformatf("p1_line%0d", k), txd, frame_bit(8'h55, k / CPB));
         @(negedge clock);
      end
      read_status(v);
      check("p1_status_idle", v, 16'h0002);
      exp.delete();
      exp.push_back(8'h55);
      compare_rx("p1", exp);

      // Back-to-back frames with interrupt on drain
      clear_rx();
      irq_rises = 0;
      write_reg(UART_CONTROL_OFFSET, 16'hFFF1);
      read_status(v);
      check("p2_irq_en", v, 16'h0012);
      write_reg(UART_DATA_OFFSET, 16'h0001);
      write_reg(UART_DATA_OFFSET, 16'h0080);
      wait_rx(2, 3 * FRAME, "p2_rx_wait");
      idle(4);
      exp.delete();
      exp.push_back(8'h01);
      exp.push_back(8'h80);
      compare_rx("p2", exp);
      check("p2_gap", start_of(1) - start_of(0), FRAME);
      check("p2_irq_rises", irq_rises, 1);
      check("p2_irq_when", irq_rise_cyc, start_of(1) + FRAME);
      write_reg(UART_CONTROL_OFFSET, 16'h0000);
      check("p2_irq_kept", irq, 1);
      pulse_reset_irq();
      check("p2_irq_cleared", irq, 0);

      // Overflow: one byte in the shifter plus DEPTH queued, the rest dropped
      clear_rx();
      exp.delete();
      for (int i = 0; i < DEPTH + 2; i++) begin
         b = 8'($urandom);
         if (i < DEPTH + 1) exp.push_back(b);
         write_reg(UART_DATA_OFFSET, {8'($urandom), b});
      end
      read_status(v);
      check("p3_status_full", v, 16'h040D);
      wait_rx(DEPTH + 1, (DEPTH + 3) * FRAME, "p3_rx_wait");
      idle(2 * FRAME);
      compare_rx("p3", exp);
      for (int i = 1; i < DEPTH + 1; i++)
         check($sformatf("p3_gap%0d", i), start_of(i) - start_of(i - 1), FRAME);
      pulse_reset_irq();
      read_status(v);
      check("p3_status_cleared", v, 16'h0002);

      // Acknowledge in the same cycle the interrupt sets
      clear_rx();
      write_reg(UART_CONTROL_OFFSET, 16'h0001);
      write_reg(UART_DATA_OFFSET, 16'(8'($urandom)));
      @(negedge clock);
      s = cyc;
      check("p4_start", txd, 0);
      while (cyc < s + FRAME - 1) @(negedge clock);
      check("p4_irq_pre", irq, 0);
      reset_irq = 1'b1;
      @(negedge clock);
      reset_irq = 1'b0;
      check("p4_irq_set_wins", irq, 1);
      @(negedge clock);
      check("p4_irq_holds", irq, 1);
      pulse_reset_irq();
      check("p4_irq_clear", irq, 0);
      write_reg(UART_CONTROL_OFFSET, 16'h0000);

      // Push coinciding with a pop at count 3, then wrap-around ordering
      idle(2);
      clear_rx();
      write_reg(UART_DATA_OFFSET, 16'h0010);
      p = cyc;
      write_reg(UART_DATA_OFFSET, 16'h0011);
      write_reg(UART_DATA_OFFSET, 16'h0012);
      write_reg(UART_DATA_OFFSET, 16'h0013);
      read_status(v);
      check("p5_count_before", {29'h0, v[10:8]}, 3);
      while (cyc < p + FRAME) @(negedge clock);
      write_enable = 1'b1;
      write_offset = UART_DATA_OFFSET;
      write_data   = 16'h0014;
      @(negedge clock);
      write_enable = 1'b0;
      read_status(v);
      check("p5_count_stays", {29'h0, v[10:8]}, 3);
      check("p5_not_full", v[0], 0);
      for (int j = 0; j < 5; j++) begin
         wait_rx(j + 2, 2 * FRAME, $sformatf("p5_rx_wait%0d", j));
         write_reg(UART_DATA_OFFSET, 16'(8'h15 + j));
      end
      wait_rx(10, 6 * FRAME, "p5_rx_wait_all");
      idle(4);
      exp.delete();
      for (int i = 0; i < 10; i++) exp.push_back(8'(8'h10 + i));
      compare_rx("p5", exp);
      read_status(v);
      check("p5_no_overflow", v[3], 0);

      // Reset in the middle of a frame aborts it and discards the queue
      clear_rx();
      write_reg(UART_DATA_OFFSET, 16'h00A5);
      p = cyc;
      write_reg(UART_DATA_OFFSET, 16'h003C);
      while (cyc < p + 1 + 2 * CPB + 1) @(negedge clock);
      check("p6_txd_mid_data", txd, 0);
      #2;
      reset = 1'b0;
      #1;
      check("p6_txd_async", txd, 1);
      read_status(v);
      check("p6_status_async", v, 16'h0002);
      idle(2);
      reset = 1'b1;
      zeros = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         @(negedge clock);
         if (txd !== 1'b1) zeros++;
      end
      check("p6_line_quiet", zeros, 0);
      check("p6_no_frames", rx_q.size(), 0);

      // Randomised bursts within FIFO capacity
      for (int r = 0; r < 3; r++) begin
         clear_rx();
         exp.delete();
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp.push_back(b);
            write_reg(UART_DATA_OFFSET, {8'($urandom), b});
         end
         wait_rx(n, (n + 2) * FRAME, $sformatf("rnd%0d_rx_wait", r));
         idle(4);
         compare_rx($sformatf("rnd%0d", r), exp);
      end
      read_status(v);
      check("final_status", v, 16'h0002);
      check("frame_errors", frame_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
